// File: rtl/ysyx_22050039_fetch_unit.sv
// rtl/ysyx_22050039_fetch_unit.sv - sequential instruction fetch with a PC-tagged fetch queue
module ysyx_22050039_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h80000000,
    parameter int              FQ_DEPTH = 4,
    parameter int              PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [XLEN-1:0]           imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [ILEN-1:0]           imem_resp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [ILEN-1:0]           out_inst,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic [ILEN-1:0] inst_mem [FQ_DEPTH];

    logic req_fire;
    logic enq;
    logic deq;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req_valid = (state_q == S_REQ) && (count_q < DEPTH_C) && !redirect_valid && !rst;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Only a response in WAIT belongs to a live request; REQ/FLUSH arrivals are dropped.
    assign enq       = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign out_valid = (count_q != '0);
    assign deq       = out_valid && out_ready && !redirect_valid;

    assign out_pc   = pc_mem[rd_ptr_q];
    assign out_inst = inst_mem[rd_ptr_q];
    assign fq_count = count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            case (state_q)
                // A response landing in the redirect cycle retires the outstanding request.
                S_WAIT, S_FLUSH: state_d = imem_resp_valid ? S_REQ : S_FLUSH;
                default:         state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT, S_FLUSH: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= req_pc_q;
            inst_mem[wr_ptr_q] <= imem_resp_data;
        end
    end

endmodule
